// File: rtl/ex_branch_resolve.sv
// Branch resolution behind the EX-stage ALU: holds the flags register and the return-address stack,
// and produces a registered PC redirect through a one-deep valid/ready output stage.
module ex_branch_resolve #(
   parameter int RAS_DEPTH = 8,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        alu_control,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [4:0]        alu_flags,
   input  logic [ADDR_W-1:0] pc_next,
   input  logic [4:0]        brfl_mask,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [4:0]        flags_q,
   output logic              ras_err
);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int IW = $clog2(RAS_DEPTH);

   localparam logic [4:0] OP_ADD  = 5'b00110;
   localparam logic [4:0] OP_SUB  = 5'b00111;
   localparam logic [4:0] OP_MUL  = 5'b01000;
   localparam logic [4:0] OP_DIV  = 5'b01001;
   localparam logic [4:0] OP_CMP  = 5'b01110;
   localparam logic [4:0] OP_JR   = 5'b10000;
   localparam logic [4:0] OP_JPC  = 5'b10001;
   localparam logic [4:0] OP_BRFL = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b10101;

   logic              out_valid_q, out_valid_d;
   logic              redirect_q, redirect_d;
   logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
   logic [4:0]        flags_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ras_err_q, ras_err_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

   logic          accept, push, ras_full, ras_empty;
   logic [IW-1:0] push_idx, top_idx;

   assign in_ready  = !reset && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
   assign ras_empty = (cnt_q == '0);
   assign push_idx  = IW'(cnt_q);
   assign top_idx   = IW'(cnt_q - CW'(1));

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      flags_d       = flags_q;
      cnt_d         = cnt_q;
      ras_err_d     = ras_err_q;
      push          = 1'b0;
      out_valid_d   = out_valid_q && !out_ready;
      redirect_d    = redirect_q;
      redirect_pc_d = redirect_pc_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         redirect_d    = 1'b0;
         redirect_pc_d = '0;
         case (alu_control)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP: flags_d = alu_flags;
            OP_JR, OP_JPC: begin
               redirect_d    = 1'b1;
               redirect_pc_d = alu_result;
            end
            OP_BRFL: begin
               // Compares against the flags held before this op; flag writers land a cycle earlier.
               if (flags_q == brfl_mask) begin
                  redirect_d    = 1'b1;
                  redirect_pc_d = alu_result;
               end
            end
            OP_CALL: begin
               redirect_d    = 1'b1;
               redirect_pc_d = alu_result;
               if (ras_full) begin
                  ras_err_d = 1'b1;
               end else begin
                  push  = 1'b1;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            OP_RET: begin
               if (ras_empty) begin
                  ras_err_d = 1'b1;
               end else begin
                  redirect_d    = 1'b1;
                  redirect_pc_d = ras_q[top_idx];
                  cnt_d         = cnt_q - CW'(1);
               end
            end
            OP_NOP:  ;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         flags_q       <= '0;
         cnt_q         <= '0;
         ras_err_q     <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         flags_q       <= flags_d;
         cnt_q         <= cnt_d;
         ras_err_q     <= ras_err_d;
      end
   end

   // NOTE: stack storage is not reset; entries above cnt_q are never read, so clearing cnt_q is enough.
   always_ff @(posedge clk) begin
      if (push) ras_q[push_idx] <= pc_next;
   end

   assign out_valid   = out_valid_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign ras_err     = ras_err_q;
endmodule

// File: tb/tb_ex_branch_resolve.sv
// Self-checking bench for ex_branch_resolve: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the stage.
module tb_ex_branch_resolve;
   localparam int DEPTH = 8;

   localparam logic [4:0] ADD = 5'b00110, SUB = 5'b00111, MUL = 5'b01000, DIV = 5'b01001;
   localparam logic [4:0] CMP = 5'b01110, JR = 5'b10000, JPC = 5'b10001, BRFL = 5'b10010;
   localparam logic [4:0] CALL = 5'b10011, RET = 5'b10100, NOP = 5'b10101;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  alu_control = NOP;
   logic [31:0] alu_result = '0;
   logic [4:0]  alu_flags = '0;
   logic [31:0] pc_next = '0;
   logic [4:0]  brfl_mask = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [4:0]  flags_q;
   logic        ras_err;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit          m_valid, m_redir, m_err;
   logic [31:0] m_pc;
   logic [4:0]  m_flags;
   logic [31:0] m_ras [$];
   bit          obs_in_ready, exp_in_ready;

   ex_branch_resolve #(.RAS_DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .alu_result(alu_result), .alu_flags(alu_flags),
      .pc_next(pc_next), .brfl_mask(brfl_mask), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .flags_q(flags_q), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   // Apply one cycle of stimulus, advance the model, and return #1 after the rising edge.
   task automatic drive(input logic [4:0] op, input logic [31:0] res, input logic [4:0] fl,
                        input logic [31:0] pcn, input logic [4:0] mask,
                        input bit iv, input bit ordy, input bit fsh);
      bit acc;
      alu_control = op; alu_result = res; alu_flags = fl; pc_next = pcn;
      brfl_mask = mask; in_valid = iv; out_ready = ordy; flush = fsh;
      #1;
      obs_in_ready = in_ready;
      exp_in_ready = !m_valid || ordy;
      acc = iv && exp_in_ready && !fsh;
      if (fsh) m_valid = 0;
      else if (acc) begin
         m_valid = 1; m_redir = 0; m_pc = '0;
         if (op inside {ADD, SUB, MUL, DIV, CMP}) m_flags = fl;
         else if (op == JR || op == JPC) begin m_redir = 1; m_pc = res; end
         else if (op == BRFL) begin
            if (m_flags == mask) begin m_redir = 1; m_pc = res; end
         end else if (op == CALL) begin
            m_redir = 1; m_pc = res;
            if (m_ras.size() == DEPTH) m_err = 1; else m_ras.push_back(pcn);
         end else if (op == RET) begin
            if (m_ras.size() > 0) begin m_redir = 1; m_pc = m_ras.pop_back(); end
            else m_err = 1;
         end
      end else if (ordy) m_valid = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_valid = 0; m_redir = 0; m_pc = '0; m_flags = '0; m_err = 0; m_ras.delete();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; alu_control = JR; alu_result = 32'h44;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      do_reset();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b exp 0", redirect); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", redirect_pc); end
      checks++; if (flags_q !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0", flags_q); end
      checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL reset_ras_err: got %b exp 0", ras_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_brfl();
      drive(CMP, 32'h5, 5'b01000, 0, 0, 1, 1, 0);
      checks++; if (flags_q !== 5'b01000) begin errors++; $display("FAIL cmp_flags: got %b exp 01000", flags_q); end
      checks++; if (out_valid !== 1'b1 || redirect !== 1'b0) begin errors++; $display("FAIL cmp_out: got v=%b r=%b exp v=1 r=0", out_valid, redirect); end
      drive(BRFL, 32'h40, 5'b11111, 0, 5'b01000, 1, 1, 0);
      checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin errors++; $display("FAIL brfl_taken: got r=%b pc=%h exp r=1 pc=00000040", redirect, redirect_pc); end
      checks++; if (flags_q !== 5'b01000) begin errors++; $display("FAIL brfl_keeps_flags: got %b exp 01000", flags_q); end
      drive(BRFL, 32'h44, 0, 0, 5'b00010, 1, 1, 0);
      checks++; if (out_valid !== 1'b1 || redirect !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL brfl_not_taken: got v=%b r=%b pc=%h exp v=1 r=0 pc=0", out_valid, redirect, redirect_pc); end
      drive(NOP, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain: got %b exp 0", out_valid); end
   endtask

   task automatic test_call_ret();
      logic [31:0] exp_pc;
      for (int i = 1; i <= 3; i++) begin
         drive(CALL, 32'h100 + i, 0, 32'h10 * i, 0, 1, 1, 0);
         checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h100 + i) begin errors++; $display("FAIL call_%0d: got r=%b pc=%h exp r=1 pc=%h", i, redirect, redirect_pc, 32'h100 + i); end
      end
      for (int i = 3; i >= 1; i--) begin
         exp_pc = 32'h10 * i;
         drive(RET, 32'hFFFF, 0, 0, 0, 1, 1, 0);
         checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) begin errors++; $display("FAIL ret_%0d: got r=%b pc=%h exp r=1 pc=%h", i, redirect, redirect_pc, exp_pc); end
      end
      drive(RET, 32'hFFFF, 0, 0, 0, 1, 1, 0);
      checks++; if (out_valid !== 1'b1 || redirect !== 1'b0 || redirect_pc !== 32'h0 || ras_err !== 1'b1) begin errors++; $display("FAIL ret_underflow: got v=%b r=%b pc=%h err=%b exp v=1 r=0 pc=0 err=1", out_valid, redirect, redirect_pc, ras_err); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(CALL, 32'h2000 + i, 0, 32'h1000 + 4 * i, 0, 1, 1, 0);
         if (i == 7) begin
            checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL full_no_err: got %b exp 0", ras_err); end
         end
      end
      checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h2008 || ras_err !== 1'b1) begin errors++; $display("FAIL call_overflow: got r=%b pc=%h err=%b exp r=1 pc=00002008 err=1", redirect, redirect_pc, ras_err); end
      for (int k = 0; k < 8; k++) begin
         exp_pc = 32'h1000 + 4 * (7 - k);
         drive(RET, 0, 0, 0, 0, 1, 1, 0);
         checks++; if (redirect !== 1'b1 || redirect_pc !== exp_pc) begin errors++; $display("FAIL ovf_ret_%0d: got r=%b pc=%h exp r=1 pc=%h", k, redirect, redirect_pc, exp_pc); end
      end
      drive(RET, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b exp 0", redirect); end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(JR, 32'h80, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         drive(JR, 32'h90, 0, 0, 0, 1, 0, 0);
         checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b exp 0", i, obs_in_ready); end
         checks++; if (out_valid !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h80) begin errors++; $display("FAIL stall_hold_%0d: got v=%b r=%b pc=%h exp v=1 r=1 pc=00000080", i, out_valid, redirect, redirect_pc); end
      end
      drive(JPC, 32'h90, 0, 0, 0, 1, 1, 0);
      checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", obs_in_ready); end
      checks++; if (out_valid !== 1'b1 || redirect_pc !== 32'h90) begin errors++; $display("FAIL drain_accept: got v=%b pc=%h exp v=1 pc=00000090", out_valid, redirect_pc); end
      drive(NOP, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", out_valid); end
   endtask

   task automatic test_flush_reset();
      do_reset();
      drive(ADD, 0, 5'b10101, 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) drive(CALL, 32'h300, 0, 32'h200 + 4 * i, 0, 1, 1, 0);
      drive(CALL, 32'h400, 0, 32'hDEAD, 0, 1, 1, 1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
      checks++; if (flags_q !== 5'b10101 || ras_err !== 1'b0) begin errors++; $display("FAIL flush_state: got f=%b err=%b exp f=10101 err=0", flags_q, ras_err); end
      drive(RET, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h210) begin errors++; $display("FAIL flush_ras: got r=%b pc=%h exp r=1 pc=00000210", redirect, redirect_pc); end
      do_reset();
      #1;
      checks++; if (flags_q !== 5'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset: got f=%b v=%b exp f=0 v=0", flags_q, out_valid); end
      drive(RET, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (redirect !== 1'b0 || ras_err !== 1'b1) begin errors++; $display("FAIL midreset_ras_empty: got r=%b err=%b exp r=0 err=1", redirect, ras_err); end
   endtask

   task automatic test_random();
      logic [4:0] ops [16] = '{ADD, SUB, MUL, DIV, CMP, JR, JPC, BRFL, BRFL, CALL, CALL, CALL, RET, RET, NOP, 5'b11111};
      logic [4:0] op, fl, mask;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         op   = ops[$urandom_range(15)];
         fl   = 5'($urandom);
         mask = ($urandom_range(1) == 1) ? m_flags : 5'($urandom);
         drive(op, $urandom, fl, $urandom, mask, $urandom_range(3) != 0,
               $urandom_range(3) != 0, $urandom_range(15) == 0);
         checks++; if (obs_in_ready !== exp_in_ready) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b exp %b", n, obs_in_ready, exp_in_ready); end
         checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b exp %b", n, out_valid, m_valid); end
         checks++; if (flags_q !== m_flags) begin errors++; $display("FAIL rnd_flags@%0d: got %b exp %b", n, flags_q, m_flags); end
         checks++; if (ras_err !== m_err) begin errors++; $display("FAIL rnd_ras_err@%0d: got %b exp %b", n, ras_err, m_err); end
         if (m_valid) begin
            checks++; if (redirect !== m_redir || redirect_pc !== m_pc) begin errors++; $display("FAIL rnd_redirect@%0d: got r=%b pc=%h exp r=%b pc=%h", n, redirect, redirect_pc, m_redir, m_pc); end
         end
         if (n == 300) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_brfl();
      test_call_ret();
      test_overflow();
      test_backpressure();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_branch_resolve.md
# ex_branch_resolve

Branch-resolution and flag-holding stage directly downstream of the EX-stage ALU. Accepts one ALU result per handshake and latches the ALU condition flags into an architectural flags register. Resolves JR/JPC/BRFL/CALL/RET into a registered PC redirect and maintains a return-address stack for CALL/RET. Feeds the fetch stage (redirect) and the EX/MEM boundary (valid/ready).

## Interface
- `RAS_DEPTH`, 8: return-address stack entries (power of two, ≥2).
- `ADDR_W`, 32: address/result width.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: ALU result valid.
- `in_ready` out 1: `!out_valid || out_ready`; forced 0 while `reset`=1.
- `alu_control` in 5: EX opcode, same encoding as the ALU (ADD 00110, SUB 00111, MUL 01000, DIV 01001, CMP 01110, JR 10000, JPC 10001, BRFL 10010, CALL 10011, RET 10100, NOP 10101).
- `alu_result` in ADDR_W: ALU result; branch target for JR/JPC/BRFL/CALL.
- `alu_flags` in 5: bit0 overflow, bit1 above, bit2 below, bit3 equal, bit4 error.
- `pc_next` in ADDR_W: return address pushed by CALL.
- `brfl_mask` in 5: BRFL comparison mask.
- `flush` in 1: squash pending output and this cycle's input.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `redirect` out 1: PC redirect taken; qualified by `out_valid`.
- `redirect_pc` out ADDR_W: redirect target.
- `flags_q` out 5: architectural flags register.
- `ras_err` out 1: sticky stack overflow/underflow error.

## Operation
- Accept = `in_valid && in_ready && !flush`. Only an accept updates flags, the RAS, or output registers.
- Flags: on accept of ADD/SUB/MUL/DIV/CMP, `flags_q <= alu_flags` (all five bits). All other opcodes hold `flags_q`.
- Resolution on accept (output register loaded, `out_valid<=1`):
  - JR, JPC: `redirect=1`, `redirect_pc=alu_result`.
  - BRFL: `redirect = (flags_q == brfl_mask)`, compared against `flags_q` *before* this accept. Target `alu_result` if taken, else 0.
  - CALL: push `pc_next`; `redirect=1`, target `alu_result`. If full (count==RAS_DEPTH): no push, `ras_err<=1`, redirect still taken.
  - RET: if count>0, pop; `redirect=1`, target = popped entry. If empty: `redirect=0`, target 0, `ras_err<=1`.
  - All other opcodes, including NOP and unknown: `redirect=0`, `redirect_pc=0`.
- RAS: LIFO; array plus count, 0..RAS_DEPTH (width `$clog2(RAS_DEPTH+1)`). Top = entry[count-1]. A full stack never wraps or overwrites.
- Output holds stable while `out_valid && !out_ready`. On `out_valid && out_ready` with no new accept, `out_valid<=0`.
- Flush: `out_valid<=0`. The input that cycle is discarded. `flags_q`, the RAS and `ras_err` are unchanged.
- `ras_err` clears only on reset.

## Timing
- Latency 1: inputs accepted in cycle N appear on outputs in cycle N+1. Full throughput (1/cycle) when `out_ready`=1.
- Simultaneous drain and accept in the same cycle: output reloads and `out_valid` stays 1.
- A flag-writing op accepted in cycle N is visible to a BRFL accepted in cycle N+1 (back-to-back forwarding through `flags_q`; no combinational bypass).
- Reset values: `out_valid`=0, `redirect`=0, `redirect_pc`=0, `flags_q`=0, RAS count=0, `ras_err`=0. Reset mid-stream drops any pending output and empties the RAS. Reset has priority over flush and accept.
- No combinational path from `alu_*` inputs to outputs; `in_ready` depends only on `out_valid`, `out_ready` and `reset`.

## Test plan
- Reset, then CMP with `alu_flags`=01000 -> next cycle `flags_q`=01000, `out_valid`=1, `redirect`=0. Then BRFL, `brfl_mask`=01000, `alu_result`=0x40 -> `redirect`=1, `redirect_pc`=0x40.
- BRFL with `brfl_mask`=00010 while `flags_q`=01000 -> `redirect`=0, `redirect_pc`=0.
- CALL ×3 (`pc_next` 0x10, 0x20, 0x30), then RET ×3 -> RET targets 0x30, 0x20, 0x10. A fourth RET gives `redirect`=0 and `ras_err`=1.
- 9 CALLs with RAS_DEPTH=8 -> 9th redirects, `ras_err`=1. Then 8 RETs return the first 8 `pc_next` values in reverse order.
- `out_ready`=0 for 3 cycles after a JR to 0x80 -> outputs held, `in_ready`=0, a second input is not consumed. Releasing `out_ready` gives a back-to-back drain plus accept.
- `flush` with `in_valid`=1 carrying CALL -> `out_valid`=0 next cycle and RAS count unchanged. Reset asserted with count=5 -> count=0, `flags_q`=0.
